// File: rtl/csa_ram.sv
// Register-mapped front end for a rotate/XOR word transformer: pops a 40-bit word,
// runs CALC_TIMES rounds of x <= rotl1(x) ^ {5{ch}}, and pushes {N, x} as 48 bits.
module csa_ram #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int OPT_MEM_ADDR_BITS  = 10,
  parameter int CSA_CALC_INST_NUM  = 4,
  parameter int CSA_CALC_IN_WIDTH  = 40,
  parameter int CSA_CALC_OUT_WIDTH = 48
) (
  input  logic                                axi_mm_clk,
  input  logic                                rst,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     wstrb,
  input  logic                                wen,
  input  logic [OPT_MEM_ADDR_BITS-1:0]        waddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       wdata,
  input  logic                                ren,
  input  logic [OPT_MEM_ADDR_BITS-1:0]        raddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       rdata,
  input  logic                                csa_in_r_ready,
  output logic                                csa_in_rclk,
  output logic                                csa_in_ren,
  input  logic [CSA_CALC_IN_WIDTH-1:0]        csa_in_rdata,
  input  logic                                csa_out_error_full,
  output logic                                csa_out_wclk,
  output logic                                csa_out_wen,
  output logic [CSA_CALC_OUT_WIDTH-1:0]       csa_out_wdata,
  input  logic                                axis_m_r_ready
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = OPT_MEM_ADDR_BITS;
  localparam int IW = CSA_CALC_IN_WIDTH;
  localparam int OW = CSA_CALC_OUT_WIDTH;
  localparam int NB = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_CALC   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [DW-1:0]   channel_index, calc_times;
  logic [DW-1:0]   mem [0:(1<<AW)-1];
  logic [DW-1:0]   rd_val;
  logic [7:0]      ch, n_q, cnt;
  logic [IW-1:0]   x, in_data;
  logic [OW-1:0]   result;
  logic            in_valid, out_valid;
  logic            pop, push, calc_done, busy;

  assign csa_in_rclk  = axi_mm_clk;
  assign csa_out_wclk = axi_mm_clk;
  assign busy         = (state != S_IDLE);

  // Control registers: byte-lane writes, RO addresses fall through untouched.
  always_ff @(posedge axi_mm_clk) begin
    if (rst) begin
      channel_index <= '0;
      calc_times    <= '0;
    end else if (wen) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) begin
          if (waddr == AW'(2))  channel_index[8*i +: 8] <= wdata[8*i +: 8];
          if (waddr == AW'(13)) calc_times[8*i +: 8]    <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Scratch RAM keeps its contents through reset.
  always_ff @(posedge axi_mm_clk) begin
    if (wen && (waddr >= AW'(14))) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (raddr)
      AW'(0):  rd_val = DW'(busy);
      AW'(1):  rd_val = DW'(!busy);
      AW'(2):  rd_val = channel_index;
      AW'(3):  rd_val = DW'(in_valid);
      AW'(4):  rd_val = DW'(in_data[7:0]);
      AW'(5):  rd_val = DW'(in_data[15:8]);
      AW'(6):  rd_val = DW'(in_data[23:16]);
      AW'(7):  rd_val = DW'(in_data[31:24]);
      AW'(8):  rd_val = DW'(in_data[39:32]);
      AW'(9):  rd_val = DW'(out_valid);
      AW'(10): rd_val = DW'(result[15:0]);
      AW'(11): rd_val = DW'(result[31:16]);
      AW'(12): rd_val = DW'(result[47:32]);
      AW'(13): rd_val = calc_times;
      default: rd_val = mem[raddr];
    endcase
  end

  // Old value wins on a same-cycle write/read because both sample pre-edge state.
  always_ff @(posedge axi_mm_clk) begin
    if (rst)      rdata <= '0;
    else if (ren) rdata <= rd_val;
  end

  always_comb begin
    state_d   = state;
    pop       = 1'b0;
    push      = 1'b0;
    calc_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (csa_in_r_ready) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_CALC;
      S_CALC: begin
        if (cnt == 8'd0) begin
          calc_done = 1'b1;
          state_d   = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (!csa_out_error_full && axis_m_r_ready) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The pop strobe is registered, so the FIFO word is taken in LOAD while it is visible.
  always_ff @(posedge axi_mm_clk) begin
    if (rst) begin
      state         <= S_IDLE;
      csa_in_ren    <= 1'b0;
      csa_out_wen   <= 1'b0;
      csa_out_wdata <= '0;
      ch            <= '0;
      n_q           <= '0;
      cnt           <= '0;
      x             <= '0;
      in_data       <= '0;
      in_valid      <= 1'b0;
      result        <= '0;
      out_valid     <= 1'b0;
    end else begin
      state       <= state_d;
      csa_in_ren  <= pop;
      csa_out_wen <= push;
      if (pop) begin
        ch  <= channel_index[7:0];
        n_q <= calc_times[7:0];
      end
      if (state == S_LOAD) begin
        x         <= csa_in_rdata;
        in_data   <= csa_in_rdata;
        in_valid  <= 1'b1;
        out_valid <= 1'b0;
        cnt       <= n_q;
      end
      if ((state == S_CALC) && (cnt != 8'd0)) begin
        x   <= {x[IW-2:0], x[IW-1]} ^ {5{ch}};
        cnt <= cnt - 8'd1;
      end
      if (calc_done) begin
        result    <= {n_q, x};
        out_valid <= 1'b1;
      end
      if (push) csa_out_wdata <= result;
    end
  end

endmodule

// File: tb/tb_csa_ram.sv
// Directed bench for csa_ram: register map, byte strobes, job flow, back-pressure
// and mid-job reset, with pushed words matched against an expected queue.
module tb_csa_ram;
  logic        clk;
  logic        rst;
  logic [3:0]  wstrb;
  logic        wen;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        ren;
  logic [9:0]  raddr;
  logic [31:0] rdata;
  logic        csa_in_r_ready;
  logic        csa_in_rclk;
  logic        csa_in_ren;
  logic [39:0] csa_in_rdata;
  logic        csa_out_error_full;
  logic        csa_out_wclk;
  logic        csa_out_wen;
  logic [47:0] csa_out_wdata;
  logic        axis_m_r_ready;

  int n_checks = 0;
  int n_errors = 0;
  int n_pushes = 0;
  logic [47:0] exp_q[$];

  csa_ram dut (
    .axi_mm_clk         (clk),
    .rst                (rst),
    .wstrb              (wstrb),
    .wen                (wen),
    .waddr              (waddr),
    .wdata              (wdata),
    .ren                (ren),
    .raddr              (raddr),
    .rdata              (rdata),
    .csa_in_r_ready     (csa_in_r_ready),
    .csa_in_rclk        (csa_in_rclk),
    .csa_in_ren         (csa_in_ren),
    .csa_in_rdata       (csa_in_rdata),
    .csa_out_error_full (csa_out_error_full),
    .csa_out_wclk       (csa_out_wclk),
    .csa_out_wen        (csa_out_wen),
    .csa_out_wdata      (csa_out_wdata),
    .axis_m_r_ready     (axis_m_r_ready)
  );

  // Clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every push must match the head of the expected queue.
  always @(negedge clk) begin
    if (csa_out_wen === 1'b1) begin
      n_pushes++;
      if (exp_q.size() == 0) check("unexpected_push", csa_out_wdata, 48'hFFFF_FFFF_FFFF ^ csa_out_wdata);
      else check("push_data", csa_out_wdata, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    wen = 1'b1; waddr = a; wdata = d; wstrb = s;
    tick(1);
    wen = 1'b0; wstrb = 4'h0;
  endtask

  task automatic reg_read(input logic [9:0] a, output logic [31:0] d);
    ren = 1'b1; raddr = a;
    tick(1);
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic read_check(input string tag, input logic [9:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(a, d);
    check(tag, 48'(d), 48'(exp));
  endtask

  task automatic start_job(input logic [39:0] word);
    bit seen = 0;
    csa_in_rdata   = word;
    csa_in_r_ready = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      if (csa_in_ren === 1'b1) seen = 1;
    end
    csa_in_r_ready = 1'b0;
    check("pop_seen", 48'(seen), 48'd1);
    tick(1);
    check("pop_one_cycle", 48'(csa_in_ren), 48'd0);
  endtask

  task automatic wait_push(input string tag, input int bound);
    int start = n_pushes;
    for (int i = 0; i < bound && n_pushes == start; i++) tick(1);
    check(tag, 48'(n_pushes - start), 48'd1);
  endtask

  task automatic run_job(input string tag, input logic [39:0] word, input logic [47:0] exp);
    exp_q.push_back(exp);
    start_job(word);
    wait_push(tag, 600);
  endtask

  initial begin
    int pushes_before;
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wstrb = 4'h0; waddr = '0; wdata = '0; raddr = '0;
    csa_in_r_ready = 1'b0; csa_in_rdata = '0; csa_out_error_full = 1'b0; axis_m_r_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);

    check("in_ren_reset", 48'(csa_in_ren), 48'd0);
    check("out_wen_reset", 48'(csa_out_wen), 48'd0);
    check("out_wdata_reset", csa_out_wdata, 48'd0);
    check("in_rclk_follows", 48'(csa_in_rclk), 48'(clk));
    check("out_wclk_follows", 48'(csa_out_wclk), 48'(clk));
    read_check("busy_reset", 10'd0, 32'd0);
    read_check("ready_reset", 10'd1, 32'd1);
    read_check("chan_reset", 10'd2, 32'd0);
    read_check("in_valid_reset", 10'd3, 32'd0);
    read_check("out_valid_reset", 10'd9, 32'd0);
    read_check("calc_times_reset", 10'd13, 32'd0);

    // N=0: result is the captured word with a zero count on top
    reg_write(10'd13, 32'd0, 4'hF);
    reg_write(10'd2, 32'd1, 4'hF);
    run_job("job_n0", 40'h12_3456_7890, 48'h00_1234_5678_90);
    read_check("in_data_0", 10'd4, 32'h90);
    read_check("in_data_4", 10'd8, 32'h12);
    read_check("in_valid", 10'd3, 32'd1);
    read_check("out_valid", 10'd9, 32'd1);
    read_check("idle_after_job", 10'd0, 32'd0);

    // N=2, ch=1, x=0: 0 -> 0101010101 -> 0303030303
    reg_write(10'd13, 32'd2, 4'hF);
    run_job("job_n2", 40'd0, 48'h02_0303_0303_03);
    read_check("out_data_0", 10'd10, 32'h0303);
    read_check("out_data_1", 10'd11, 32'h0303);
    read_check("out_data_2", 10'd12, 32'h0203);
    read_check("out_valid_n2", 10'd9, 32'd1);

    // N=1, ch=A5, x=8000000001: rotl1 gives 0000000003, xor A5.. -> A5A5A5A5A6
    reg_write(10'd13, 32'd1, 4'hF);
    reg_write(10'd2, 32'hA5, 4'hF);
    run_job("job_n1", 40'h80_0000_0001, 48'h01_A5A5_A5A5_A6);
    read_check("in_data_2", 10'd6, 32'h00);

    // Back-pressure hold; channel written mid-job must not affect this job
    reg_write(10'd13, 32'd2, 4'hF);
    reg_write(10'd2, 32'd1, 4'hF);
    csa_out_error_full = 1'b1;
    exp_q.push_back(48'h02_0303_0303_03);
    pushes_before = n_pushes;
    start_job(40'd0);
    reg_write(10'd2, 32'hFF, 4'hF);
    tick(20);
    check("no_push_when_full", 48'(n_pushes), 48'(pushes_before));
    read_check("busy_held", 10'd0, 32'd1);
    read_check("ready_held", 10'd1, 32'd0);
    axis_m_r_ready = 1'b0;
    csa_out_error_full = 1'b0;
    tick(5);
    check("no_push_not_ready", 48'(n_pushes), 48'(pushes_before));
    axis_m_r_ready = 1'b1;
    wait_push("push_after_release", 2);
    tick(3);
    check("single_push", 48'(n_pushes), 48'(pushes_before + 1));

    // Next job picks up ch=FF: FFFFFFFFFF then rotl1 xor FF.. -> 0
    run_job("job_ch_ff", 40'd0, 48'h02_0000_0000_00);

    // Scratch RAM byte strobes, RO writes ignored, read-before-write ordering
    reg_write(10'd20, 32'd0, 4'hF);
    reg_write(10'd20, 32'hDEAD_BEEF, 4'b0011);
    read_check("scratch_strobe", 10'd20, 32'h0000_BEEF);
    reg_write(10'd0, 32'hFFFF_FFFF, 4'hF);
    read_check("busy_ro", 10'd0, 32'd0);
    reg_write(10'd1, 32'd0, 4'hF);
    read_check("ready_ro", 10'd1, 32'd1);
    reg_write(10'd2, 32'h1122_3344, 4'b0100);
    read_check("chan_strobe", 10'd2, 32'h0022_00FF);
    reg_write(10'd21, 32'h1111_1111, 4'hF);
    wen = 1'b1; waddr = 10'd21; wdata = 32'h2222_2222; wstrb = 4'hF;
    ren = 1'b1; raddr = 10'd21;
    tick(1);
    wen = 1'b0; ren = 1'b0; wstrb = 4'h0;
    check("same_cycle_old", 48'(rdata), 48'h1111_1111);
    tick(2);
    check("rdata_holds", 48'(rdata), 48'h1111_1111);
    read_check("same_cycle_new", 10'd21, 32'h2222_2222);

    // Reset during CALC aborts the job
    reg_write(10'd2, 32'd1, 4'hF);
    reg_write(10'd13, 32'd200, 4'hF);
    pushes_before = n_pushes;
    start_job(40'h55_AA55_AA55);
    tick(20);
    read_check("busy_in_calc", 10'd0, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("wen_after_rst", 48'(csa_out_wen), 48'd0);
    check("wdata_after_rst", csa_out_wdata, 48'd0);
    check("rdata_after_rst", 48'(rdata), 48'd0);
    read_check("busy_after_rst", 10'd0, 32'd0);
    read_check("ready_after_rst", 10'd1, 32'd1);
    read_check("in_valid_after_rst", 10'd3, 32'd0);
    read_check("in_data_after_rst", 10'd4, 32'd0);
    read_check("out_valid_after_rst", 10'd9, 32'd0);
    read_check("out_data_after_rst", 10'd12, 32'd0);
    read_check("chan_after_rst", 10'd2, 32'd0);
    read_check("calc_after_rst", 10'd13, 32'd0);
    read_check("scratch_kept", 10'd20, 32'h0000_BEEF);
    tick(250);
    check("no_push_after_abort", 48'(n_pushes), 48'(pushes_before));
    check("exp_q_drained", 48'(exp_q.size()), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
